// File: rtl/ws2812_serializer_if.sv
// Pixel stream handshake between the LED controller core and the WS2812 serializer.
// The master drives a GRB word plus an end-of-frame flag, and the slave answers with ready.
interface ws2812_serializer_if;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output pix_data,
    output pix_last,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_last,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/ws2812_serializer.sv
// WS2812 one-wire encoder. It shifts 24-bit GRB words out MSB first as high/low pulse pairs
// and closes each frame with a latch-low period. All timing is counted in clk cycles.
module ws2812_serializer #(
  parameter int BIT_CYC   = 13,
  parameter int T0H_CYC   = 4,
  parameter int T1H_CYC   = 8,
  parameter int RESET_CYC = 600
) (
  input  logic                      clk,
  input  logic                      rst,
  ws2812_serializer_if.slave        pix,
  output logic                      dout,
  output logic                      busy,
  output logic                      underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [7:0]  BIT_LAST = 8'(BIT_CYC - 1);
  localparam logic [7:0]  T0H      = 8'(T0H_CYC);
  localparam logic [7:0]  T1H      = 8'(T1H_CYC);
  localparam logic [15:0] LAT_LAST = 16'(RESET_CYC - 1);

  state_t      state;
  logic [23:0] shreg;
  logic        last_q;
  logic [4:0]  bit_idx;
  logic [7:0]  cyc;
  logic [15:0] lat_cnt;

  logic [7:0]  cyc_next;
  logic        shift_level;
  logic        bit_end;
  logic        word_end;

  // dout is registered, so the level for the next cycle is computed from the next cycle count.
  always_comb begin
    cyc_next    = cyc + 8'd1;
    shift_level = (cyc_next < (shreg[23] ? T1H : T0H));
    bit_end     = (cyc == BIT_LAST);
    word_end    = bit_end && (bit_idx == 5'd0);
  end

  // Ready opens in IDLE and in the final cycle of a non-last word, which lets the next word
  // follow with no gap on the line.
  assign pix.pix_ready = (state == IDLE) || ((state == SHIFT) && word_end && !last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= 24'd0;
      last_q   <= 1'b0;
      bit_idx  <= 5'd0;
      cyc      <= 8'd0;
      lat_cnt  <= 16'd0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          dout <= 1'b0;
          if (pix.pix_valid) begin
            shreg   <= pix.pix_data;
            last_q  <= pix.pix_last;
            bit_idx <= 5'd23;
            cyc     <= 8'd0;
            dout    <= 1'b1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (!bit_end) begin
            cyc  <= cyc_next;
            dout <= shift_level;
          end else if (bit_idx != 5'd0) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_idx <= bit_idx - 5'd1;
            cyc     <= 8'd0;
            dout    <= 1'b1;
          end else if (last_q) begin
            cyc     <= 8'd0;
            lat_cnt <= 16'd0;
            dout    <= 1'b0;
            state   <= LATCH;
          end else if (pix.pix_valid) begin
            shreg   <= pix.pix_data;
            last_q  <= pix.pix_last;
            bit_idx <= 5'd23;
            cyc     <= 8'd0;
            dout    <= 1'b1;
          end else begin
            // Upstream failed to supply the next word of an open frame.
            shreg    <= 24'd0;
            cyc      <= 8'd0;
            dout     <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b1;
            state    <= IDLE;
          end
        end

        LATCH: begin
          dout <= 1'b0;
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= 16'd0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 16'd1;
          end
        end

        default: begin
          dout  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer. Words are pushed to a scoreboard when driven and popped
// when their 24 encoded bits appear on dout, cycle by cycle.
module tb_ws2812_serializer;

  localparam int BIT_CYC   = 13;
  localparam int T0H_CYC   = 4;
  localparam int T1H_CYC   = 8;
  localparam int RESET_CYC = 600;
  localparam int WAIT_MAX  = 2000;

  typedef struct {
    logic [23:0] data;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dout;
  logic busy;
  logic underrun;

  int checks   = 0;
  int failures = 0;

  word_t sb[$];

  ws2812_serializer_if pix ();

  ws2812_serializer #(
    .BIT_CYC  (BIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .RESET_CYC(RESET_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pix     (pix.slave),
    .dout    (dout),
    .busy    (busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive a word, record it on the scoreboard and wait (bounded) for the acceptance edge.
  // Returns in the cycle right after acceptance.
  task automatic applyStimulus(input string tag, input logic [23:0] data, input logic last,
                               input int exp_wait);
    word_t w;
    int n;
    w.data = data;
    w.last = last;
    sb.push_back(w);
    pix.pix_data  = data;
    pix.pix_last  = last;
    pix.pix_valid = 1'b1;
    n = 0;
    while (pix.pix_ready !== 1'b1 && n < WAIT_MAX) begin
      step();
      n++;
    end
    checkOutput({tag, "_accept_wait"}, n, exp_wait);
    step();
    pix.pix_valid = 1'b0;
  endtask

  // Pops one scoreboard word and compares each 13-cycle bit window of dout against the model.
  task automatic checkWord(input string tag, input logic exp_ready_last);
    word_t w;
    int busy_bad;
    int und_bad;
    int ready_bad;
    logic accepted;
    busy_bad  = 0;
    und_bad   = 0;
    ready_bad = 0;
    accepted  = 1'b0;
    if (sb.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 1, 0);
      w.data = 24'd0;
      w.last = 1'b0;
    end else begin
      w = sb.pop_front();
    end
    for (int b = 0; b < 24; b++) begin
      logic [BIT_CYC-1:0] obs_bits;
      logic [BIT_CYC-1:0] exp_bits;
      for (int k = 0; k < BIT_CYC; k++) begin
        logic final_cyc;
        final_cyc = (b == 23) && (k == BIT_CYC - 1);
        exp_bits[BIT_CYC-1-k] = (k < (w.data[23-b] ? T1H_CYC : T0H_CYC));
        obs_bits[BIT_CYC-1-k] = dout;
        if (busy !== 1'b1) busy_bad++;
        if (underrun !== 1'b0) und_bad++;
        if (!final_cyc && pix.pix_ready !== 1'b0) ready_bad++;
        if (final_cyc) begin
          checkOutput({tag, "_ready_last"}, 32'(pix.pix_ready), 32'(exp_ready_last));
          accepted = (pix.pix_ready === 1'b1) && (pix.pix_valid === 1'b1);
        end
        step();
        if (final_cyc && accepted) pix.pix_valid = 1'b0;
      end
      checkOutput($sformatf("%s_bit%0d", tag, b), 32'(obs_bits), 32'(exp_bits));
    end
    checkOutput({tag, "_busy_low_cycles"}, busy_bad, 0);
    checkOutput({tag, "_underrun_cycles"}, und_bad, 0);
    checkOutput({tag, "_ready_early_cycles"}, ready_bad, 0);
  endtask

  // Latch period: dout and ready low, busy high for RESET_CYC cycles, then IDLE.
  task automatic checkLatch(input string tag, input logic inject);
    int bad;
    bad = 0;
    for (int i = 0; i < RESET_CYC; i++) begin
      if (dout !== 1'b0 || pix.pix_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (inject && i == 100) begin
        pix.pix_data  = 24'hFFFFFF;
        pix.pix_last  = 1'b1;
        pix.pix_valid = 1'b1;
      end
      step();
    end
    checkOutput({tag, "_latch_bad_cycles"}, bad, 0);
    checkOutput({tag, "_idle_ready"}, 32'(pix.pix_ready), 1);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    pix.pix_data  = 24'd0;
    pix.pix_last  = 1'b0;
    pix.pix_valid = 1'b0;

    // Reset held for two edges.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_dout", 32'(dout), 0);
    checkOutput("reset_ready", 32'(pix.pix_ready), 1);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_underrun", 32'(underrun), 0);

    // Single pixel frame.
    applyStimulus("single", 24'hFF0000, 1'b1, 0);
    checkWord("single", 1'b0);
    checkLatch("single", 1'b0);

    // Back-to-back: second word waits on valid while ready is low.
    applyStimulus("b2b_a", 24'hAAAAAA, 1'b0, 0);
    begin
      word_t w2;
      w2.data = 24'h000001;
      w2.last = 1'b1;
      sb.push_back(w2);
      pix.pix_data  = w2.data;
      pix.pix_last  = w2.last;
      pix.pix_valid = 1'b1;
    end
    checkWord("b2b_a", 1'b1);
    checkWord("b2b_b", 1'b0);
    checkLatch("b2b", 1'b0);

    // Underrun: non-last word with no follow-up.
    applyStimulus("under", 24'h123456, 1'b0, 0);
    checkWord("under", 1'b1);
    checkOutput("under_pulse", 32'(underrun), 1);
    checkOutput("under_busy", 32'(busy), 0);
    checkOutput("under_dout", 32'(dout), 0);
    checkOutput("under_ready", 32'(pix.pix_ready), 1);
    step();
    checkOutput("under_pulse_end", 32'(underrun), 0);

    // Valid raised mid-latch is held off until the first IDLE cycle.
    applyStimulus("latch_frame", 24'h5A5A5A, 1'b1, 0);
    checkWord("latch_frame", 1'b0);
    checkLatch("latch_frame", 1'b1);
    applyStimulus("held_word", 24'hFFFFFF, 1'b1, 0);
    checkWord("held_word", 1'b0);
    checkLatch("held_word", 1'b0);

    // Reset in the middle of a high pulse.
    applyStimulus("midrst", 24'hF0F0F0, 1'b1, 0);
    for (int i = 0; i < 39; i++) step();
    checkOutput("midrst_dout_before", 32'(dout), 1);
    checkOutput("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_dout", 32'(dout), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_ready", 32'(pix.pix_ready), 1);
    checkOutput("midrst_underrun", 32'(underrun), 0);
    if (sb.size() != 0) void'(sb.pop_front());
    applyStimulus("post_rst", 24'h0F00FF, 1'b1, 0);
    checkWord("post_rst", 1'b0);
    checkLatch("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
